// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/func/state enums and instruction field offsets for param_multicycle_cpu
package cpu_pkg;
  typedef enum logic [1:0] {OP_ADDI, OP_ALU, OP_LOAD, OP_STORE} op_e;
  typedef enum logic [2:0] {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT} func_e;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
  localparam int IMM_LSB = 4;
  function automatic int instr_width(input int rb, input int dw);
    return 2 + 3 * rb + dw + 4;
  endfunction
  function automatic int x3_lsb(input int dw);
    return dw + 4;
  endfunction
  function automatic int x2_lsb(input int rb, input int dw);
    return dw + 4 + rb;
  endfunction
  function automatic int x1_lsb(input int rb, input int dw);
    return dw + 4 + 2 * rb;
  endfunction
endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: 2**REG_BITS x DATA_WIDTH registers, two operand reads + debug read, one write, reset to index values
module cpu_regfile import cpu_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_BITS-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [REG_BITS-1:0]   ra,
  input  logic [REG_BITS-1:0]   rb,
  input  logic [REG_BITS-1:0]   dbg_addr,
  output logic [DATA_WIDTH-1:0] ra_data,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic [DATA_WIDTH-1:0] dbg_data
);
  logic [DATA_WIDTH-1:0] rf [2**REG_BITS];
  assign ra_data = rf[ra];
  assign rb_data = rf[rb];
  assign dbg_data = rf[dbg_addr];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**REG_BITS; i++) rf[i] <= DATA_WIDTH'(i);
    end else if (we) begin
      rf[waddr] <= wdata;
    end
  end
endmodule

// File: rtl/param_multicycle_cpu.sv
// param_multicycle_cpu: multi-cycle CPU (FETCH/DECODE/EXEC/MEM/WB) with valid/ready fetch, retire/illegal pulses, result/zero and debug register port
module param_multicycle_cpu import cpu_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS = 5,
  parameter int REG_BITS = 2,
  parameter int INSTR_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic                   retire,
  output logic                   illegal,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   zero,
  input  logic [REG_BITS-1:0]    dbg_addr,
  output logic [DATA_WIDTH-1:0]  dbg_data
);
  if (INSTR_WIDTH != instr_width(REG_BITS, DATA_WIDTH)) begin : g_bad_width
    $error("INSTR_WIDTH must equal 2+3*REG_BITS+DATA_WIDTH+4");
  end
  localparam int X1L = x1_lsb(REG_BITS, DATA_WIDTH);
  localparam int X2L = x2_lsb(REG_BITS, DATA_WIDTH);
  localparam int X3L = x3_lsb(DATA_WIDTH);
  state_e state;
  logic [INSTR_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] a, b, alu_r, mdr, alu, rd_a, rd_b, wdata, imm;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
  logic [REG_BITS-1:0] x1, x2, x3;
  logic [ADDR_BITS-1:0] addr;
  logic [2:0] func;
  logic bad, unused_ok;
  op_e op;
  assign op = op_e'(ir[INSTR_WIDTH-1 -: 2]);
  assign x1 = ir[X1L +: REG_BITS];
  assign x2 = ir[X2L +: REG_BITS];
  assign x3 = ir[X3L +: REG_BITS];
  assign imm = ir[IMM_LSB +: DATA_WIDTH];
  assign func = ir[2:0];
  assign unused_ok = ir[3];
  assign bad = op == OP_ALU && func[2:1] == 2'b11;
  assign addr = ADDR_BITS'(alu_r);
  assign wdata = op == OP_LOAD ? mdr : alu_r;
  assign instr_ready = state == S_FETCH && !rst;
  always_comb begin
    alu = op != OP_ALU ? a + imm :
          func == F_SUB ? a - b :
          func == F_AND ? a & b :
          func == F_OR  ? a | b :
          func == F_XOR ? a ^ b :
          func == F_SLT ? DATA_WIDTH'(a < b) : a + b;
  end
  cpu_regfile #(.DATA_WIDTH(DATA_WIDTH), .REG_BITS(REG_BITS)) u_rf (
    .clk(clk), .rst(rst), .we(state == S_WB), .waddr(x1), .wdata(wdata),
    .ra(x2), .rb(op == OP_STORE ? x1 : x3), .dbg_addr(dbg_addr),
    .ra_data(rd_a), .rb_data(rd_b), .dbg_data(dbg_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      retire <= 1'b0;
      illegal <= 1'b0;
      result <= '0;
      zero <= 1'b1;
      for (int i = 0; i < 2**ADDR_BITS; i++) mem[i] <= '0;
    end else begin
      retire <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_FETCH: if (instr_valid) begin
          ir <= instruction;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a <= rd_a;
          b <= rd_b;
          state <= S_EXEC;
        end
        S_EXEC: begin
          alu_r <= alu;
          retire <= bad;
          illegal <= bad;
          state <= bad ? S_FETCH : (op == OP_LOAD || op == OP_STORE) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (op == OP_STORE) mem[addr] <= b;
          else mdr <= mem[addr];
          retire <= op == OP_STORE;
          state <= op == OP_STORE ? S_FETCH : S_WB;
        end
        S_WB: begin
          result <= wdata;
          zero <= wdata == '0;
          retire <= 1'b1;
          state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_param_multicycle_cpu.sv
// tb_param_multicycle_cpu: scoreboard bench for param_multicycle_cpu (default and REG_BITS=3 instances)
module tb_param_multicycle_cpu;
  typedef struct {logic [7:0] res; logic z; logic ill; int lat;} exp_t;
  logic clk, rst;
  logic [19:0] instruction;
  logic instr_valid, instr_ready, retire, illegal, zero;
  logic [7:0] result, dbg_data;
  logic [1:0] dbg_addr;
  logic [22:0] ins3;
  logic v3, rdy3, ret3, ill3, z3;
  logic [7:0] res3, dbgd3;
  logic [2:0] dbga3;
  logic [7:0] m_rf [4];
  logic [7:0] m_mem [32];
  logic [7:0] m_res;
  logic m_zero;
  exp_t q[$];
  int errors = 0, checks = 0;
  param_multicycle_cpu dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .retire(retire), .illegal(illegal), .result(result),
    .zero(zero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  param_multicycle_cpu #(.REG_BITS(3), .INSTR_WIDTH(23)) dut3 (
    .clk(clk), .rst(rst), .instruction(ins3), .instr_valid(v3),
    .instr_ready(rdy3), .retire(ret3), .illegal(ill3), .result(res3),
    .zero(z3), .dbg_addr(dbga3), .dbg_data(dbgd3)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [19:0] mk(input int op, input int x1, input int x2, input int x3, input int imm, input int f);
    return {2'(op), 2'(x1), 2'(x2), 2'(x3), 8'(imm), 1'b0, 3'(f)};
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'(i);
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_res = '0;
    m_zero = 1'b1;
  endtask
  task automatic model(input logic [19:0] ins, output exp_t e);
    logic [1:0] op, x1, x2, x3;
    logic [7:0] imm, v, a, b;
    logic [2:0] f;
    logic [4:0] a5;
    op = ins[19:18]; x1 = ins[17:16]; x2 = ins[15:14]; x3 = ins[13:12];
    imm = ins[11:4]; f = ins[2:0];
    a = m_rf[x2]; b = m_rf[x3];
    a5 = 5'(a + imm);
    e.ill = 1'b0; e.lat = 3; v = '0;
    case (op)
      2'd0: v = a + imm;
      2'd1: case (f)
        3'd0: v = a + b;
        3'd1: v = a - b;
        3'd2: v = a & b;
        3'd3: v = a | b;
        3'd4: v = a ^ b;
        3'd5: v = {7'b0, a < b};
        default: begin e.ill = 1'b1; e.lat = 2; end
      endcase
      2'd2: begin v = m_mem[a5]; e.lat = 4; end
      default: m_mem[a5] = m_rf[x1];
    endcase
    if (!e.ill && op != 2'd3) begin
      m_rf[x1] = v;
      m_res = v;
      m_zero = v == 0;
    end
    e.res = m_res;
    e.z = m_zero;
  endtask
  task automatic dbg_all();
    for (int r = 0; r < 4; r++) begin
      dbg_addr = 2'(r);
      #1 chk($sformatf("rf%0d", r), dbg_data, m_rf[r]);
    end
  endtask
  task automatic issue(input logic [19:0] ins);
    exp_t e;
    int n;
    model(ins, e);
    q.push_back(e);
    @(negedge clk);
    chk("ready", instr_ready, 1);
    instruction = ins;
    instr_valid = 1;
    @(posedge clk);
    #1 instr_valid = 0;
    instruction = '1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!retire && n < 8);
    chk("retire", retire, 1);
    e = q.pop_front();
    chk("latency", n, e.lat);
    chk("illegal", illegal, e.ill);
    chk("result", result, e.res);
    chk("zero", zero, e.z);
    @(posedge clk);
    #1 chk("retire_pulse", retire, 0);
    chk("ready_after", instr_ready, 1);
    dbg_all();
  endtask
  initial begin
    int n;
    rst = 1; instruction = '0; instr_valid = 0; dbg_addr = '0;
    ins3 = '0; v3 = 0; dbga3 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", instr_ready, 0);
    chk("rst_retire", retire, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    dbg_all();
    @(negedge clk);
    rst = 0;
    issue(20'b01000111000000000000);
    issue(mk(1, 1, 0, 3, 0, 0));
    issue(mk(1, 3, 0, 2, 0, 1));
    issue(20'b11011000000011110000);
    issue(20'b10111000000011110000);
    issue(mk(3, 0, 3, 0, 255, 0));
    issue(mk(2, 2, 0, 0, 2, 0));
    issue(mk(0, 2, 2, 0, 8'hA1, 0));
    issue(mk(1, 1, 1, 2, 0, 2));
    issue(mk(1, 0, 0, 2, 0, 3));
    issue(mk(1, 3, 3, 2, 0, 4));
    issue(mk(1, 1, 1, 2, 0, 5));
    issue(mk(1, 1, 2, 1, 0, 5));
    issue(mk(1, 0, 1, 3, 0, 1));
    issue(mk(0, 3, 3, 0, 8'h5E, 0));
    issue(mk(1, 2, 2, 2, 0, 0));
    issue(mk(1, 0, 1, 2, 0, 6));
    issue(mk(1, 3, 0, 0, 0, 7));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ready", instr_ready, 1);
      chk("idle_retire", retire, 0);
    end
    @(negedge clk);
    instruction = mk(0, 0, 0, 0, 5, 0);
    instr_valid = 1;
    @(posedge clk);
    #1 instr_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    #1 chk("midrst_ready", instr_ready, 0);
    @(posedge clk);
    #1 chk("midrst_retire", retire, 0);
    chk("midrst_ready2", instr_ready, 0);
    model_reset();
    dbg_all();
    @(negedge clk);
    rst = 0;
    #1 chk("postrst_ready", instr_ready, 1);
    chk("postrst_result", result, 0);
    chk("postrst_zero", zero, 1);
    issue(mk(2, 1, 0, 0, 17, 0));
    chk("sb_empty", q.size(), 0);
    @(negedge clk);
    dbga3 = 3'd7;
    #1 chk("r3_rf7_init", dbgd3, 7);
    chk("r3_ready", rdy3, 1);
    ins3 = {2'b00, 3'd7, 3'd6, 3'd0, 8'd250, 1'b0, 3'd0};
    v3 = 1;
    @(posedge clk);
    #1 v3 = 0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!ret3 && n < 8);
    chk("r3_retire", ret3, 1);
    chk("r3_latency", n, 3);
    chk("r3_illegal", ill3, 0);
    chk("r3_result", res3, 0);
    chk("r3_zero", z3, 1);
    @(negedge clk);
    dbga3 = 3'd7;
    #1 chk("r3_rf7", dbgd3, 0);
    dbga3 = 3'd6;
    #1 chk("r3_rf6", dbgd3, 6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
